// File: rtl/path_player_if.sv
// Path-replay bundle: start/length request, path memory read port, move handshake and status.
// master = the player, slave = the solver/memory/consumer environment around it.
interface path_player_if #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 4
);
    logic               run;
    logic [ADDR_W:0]    path_len;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [1:0]         rd_data;
    logic [1:0]         move;
    logic               move_valid;
    logic               move_ready;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  run, path_len, rd_data, move_ready,
        output rd_en, rd_addr, move, move_valid, x, y, busy, done, err
    );

    modport slave (
        output run, path_len, rd_data, move_ready,
        input  rd_en, rd_addr, move, move_valid, x, y, busy, done, err
    );
endinterface

// File: rtl/path_player.sv
// Replays a solved maze path from memory index 0 upward, one move per valid/ready handshake, tracking (x, y).
// Latency: first move 3 edges after run; with move_ready high one move per 3 cycles; holds move while move_ready is low.
module path_player #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    path_player_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [COORD_W-1:0] C_MAX = '1;

    state_t             r_state;
    logic [ADDR_W:0]    r_idx;
    logic [ADDR_W:0]    r_len;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [1:0]         r_move;
    logic               r_move_valid;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_off_grid;
    logic [ADDR_W:0]    w_idx_nx;
    logic [COORD_W-1:0] w_x_nx;
    logic [COORD_W-1:0] w_y_nx;

    // A move leaves the grid only when it pushes against the edge it points at.
    assign w_off_grid = (bus.rd_data == 2'b10 && r_x == '0)    ||
                        (bus.rd_data == 2'b01 && r_x == C_MAX) ||
                        (bus.rd_data == 2'b00 && r_y == '0)    ||
                        (bus.rd_data == 2'b11 && r_y == C_MAX);

    assign w_idx_nx = r_idx + 1'b1;

    // Axis is the XOR of the move bits (1 = x), bit 0 selects +1 versus -1.
    always_comb begin
        w_x_nx = r_x;
        w_y_nx = r_y;
        if (^r_move) begin
            w_x_nx = r_move[0] ? r_x + 1'b1 : r_x - 1'b1;
        end else begin
            w_y_nx = r_move[0] ? r_y + 1'b1 : r_y - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_move       <= 2'b00;
            r_move_valid <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_move_valid <= 1'b0;
                    if (bus.run) begin
                        r_len <= bus.path_len;
                        r_idx <= '0;
                        r_x   <= '0;
                        r_y   <= '0;
                        r_err <= 1'b0;
                        if (bus.path_len == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_done    <= 1'b0;
                            r_busy    <= 1'b1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_off_grid) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_move       <= bus.rd_data;
                        r_move_valid <= 1'b1;
                        r_state      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (bus.move_ready) begin
                        r_x          <= w_x_nx;
                        r_y          <= w_y_nx;
                        r_move_valid <= 1'b0;
                        r_idx        <= w_idx_nx;
                        if (w_idx_nx == r_len) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_idx_nx[ADDR_W-1:0];
                            r_state   <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_en      = r_rd_en;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.move       = r_move;
    assign bus.move_valid = r_move_valid;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule

// File: doc/path_player.md
Name: path_player

Overview:
- Replays a solved maze path; the read-side counterpart of the rat solver's direction stack.
- The solver pushes one 2-bit direction per forward step into path memory. This block reads that memory from bottom (index 0) to top, in push order.
- It emits one move per entry over a valid/ready handshake and tracks the rat's (x, y) position.
- It sits between the path memory read port and the motion/display logic, started by `run` after the solver asserts done.

Parameters:
- ADDR_W, 8, path memory address width; max path length 2^ADDR_W entries.
- COORD_W, 4, width of the x and y coordinates; grid is 2^COORD_W by 2^COORD_W.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- run  in  1  start request; sampled only in IDLE and DONE.
- path_len  in  ADDR_W+1  number of valid path entries (solver stack pointer); sampled when run is accepted.
- rd_en  out  1  path memory read strobe.
- rd_addr  out  ADDR_W  path memory read address.
- rd_data  in  2  direction read; valid the cycle after rd_en.
- move  out  2  current direction: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
- move_valid  out  1  move is presented.
- move_ready  in  1  consumer accepts move.
- x  out  COORD_W  current column.
- y  out  COORD_W  current row.
- busy  out  1  replay in progress.
- done  out  1  replay finished; level signal.
- err  out  1  replay aborted on an off-grid move; level signal.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, idx=0, len=0.
  - All outputs 0: rd_en, rd_addr, move, move_valid, x, y, busy, done, err.
  - rst=1 mid-replay aborts immediately; move_valid drops on that same edge.
- Direction decode: axis = XOR of move bits (1 = x, 0 = y); increment = move[0] (1 = +1, 0 = -1).
- IDLE:
  - run=1: latch len=path_len, idx=0, x=y=0, done=err=0, busy=1.
  - Then go to DONE if path_len==0 (busy=0, done=1 next cycle); otherwise go to FETCH.
- FETCH (one cycle): rd_en=1, rd_addr=idx; go to WAIT.
- WAIT (one cycle), rd_data valid this cycle:
  - Compute the target coordinate.
  - Off-grid target means x=0 with 10, x=max with 01, y=0 with 00, or y=max with 11. In that case: err=1, done=1, busy=0, go to DONE; no move is presented and x/y stay unchanged.
  - Otherwise register move=rd_data, set move_valid=1, go to PRESENT.
- PRESENT:
  - Hold move and move_valid stable until move_ready=1.
  - On the handshake edge: update x/y by ±1, move_valid=0, idx=idx+1.
  - If idx+1==len: go to DONE (done=1, busy=0). Otherwise go to FETCH.
- DONE:
  - done (and err, if it was set) held; move_valid=0.
  - run=1 restarts exactly as in IDLE.
- Timing:
  - run accepted at edge T; first move_valid high after edge T+2 (FETCH T+1, WAIT T+2).
  - With move_ready tied high, one move every 3 cycles.
  - done rises on the edge after the final handshake.
- run while busy is ignored.
- move_ready outside PRESENT is ignored.
- rd_en is high only in FETCH; rd_addr holds its last value otherwise.
- A path_len value above 2^ADDR_W is the solver's error and is undefined.
- idx never wraps: replay ends when idx reaches len.

Test Plan:
- Reset then run with path_len=3, memory {01,11,01}, move_ready=1 → moves 01,11,01, each move_valid one cycle, 3 cycles apart; first move_valid on the 3rd edge after run; final x=2, y=1, done=1, err=0.
- path_len=0, run → done=1 on the next edge; rd_en and move_valid never assert; x=y=0.
- Backpressure: path_len=2, move_ready low for 5 cycles on the first move → move and move_valid held unchanged; x stays 0 until move_ready rises, then x/y update on that edge.
- Off-grid: memory[0]=00 at y=0 → err=1, done=1, move_valid never asserts, x=y=0.
- rst asserted while in PRESENT → next edge all outputs 0 and state IDLE; a subsequent run replays from index 0.
- run pulsed mid-replay is ignored; run in DONE restarts with x=y=0 and done/err cleared.
